// File: rtl/dma_seg_ram_pkg.sv
// Shared constants and helpers for the segmented DMA RAM blocks.
package dma_seg_ram_pkg;

  localparam int PIPELINE_MIN = 1;
  localparam int PIPELINE_MAX = 4;
  localparam int STAT_WIDTH   = 32;

  // The output FIFO must hold every read in flight plus the entry being presented.
  function automatic int min_fifo_addr_width(input int pipeline);
    int w;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      w = ((32'sd1 <<< w) < (pipeline + 32'sd1)) ? (w + 32'sd1) : w;
    end
    return w;
  endfunction

  function automatic int sel_port_width(input int sel_width);
    return (sel_width > 32'sd0) ? sel_width : 32'sd1;
  endfunction

endpackage

// File: rtl/dma_seg_ram_rd_if.sv
// Segmented RAM bus: write port plus read command/response channels, one lane per segment.
interface dma_seg_ram_rd_if
  import dma_seg_ram_pkg::*;
#(
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int RAM_SEL_WIDTH  = 2
);

  localparam int SEL_W = sel_port_width(RAM_SEL_WIDTH);

  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data;
  logic [SEG_COUNT-1:0]                wr_cmd_valid;
  logic [SEG_COUNT-1:0]                wr_cmd_ready;
  logic [SEG_COUNT-1:0]                wr_done;
  logic [SEG_COUNT*SEL_W-1:0]          rd_cmd_sel;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [SEG_COUNT-1:0]                rd_cmd_valid;
  logic [SEG_COUNT-1:0]                rd_cmd_ready;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;
  logic [SEG_COUNT-1:0]                rd_resp_valid;
  logic [SEG_COUNT-1:0]                rd_resp_ready;

  modport master (
    output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    input  wr_cmd_ready, wr_done,
    output rd_cmd_sel, rd_cmd_addr, rd_cmd_valid,
    input  rd_cmd_ready,
    input  rd_resp_data, rd_resp_valid,
    output rd_resp_ready
  );

  modport slave (
    input  wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    output wr_cmd_ready, wr_done,
    input  rd_cmd_sel, rd_cmd_addr, rd_cmd_valid,
    output rd_cmd_ready,
    output rd_resp_data, rd_resp_valid,
    input  rd_resp_ready
  );

endinterface

// File: rtl/dma_seg_ram_rd_seg.sv
// One RAM segment: byte-enabled storage, PIPELINE-deep read path, credit-limited output FIFO.
// DMA_SEG_RAM_RD_STAT_EN adds a completed-response counter output.
module dma_seg_ram_rd_seg
  import dma_seg_ram_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int PIPELINE        = 2,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready
`ifdef DMA_SEG_RAM_RD_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_count
`endif
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int FIFO_DEPTH = 2 ** FIFO_ADDR_WIDTH;

  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;
  localparam ptr_t CREDIT_LIMIT = ptr_t'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic [DATA_WIDTH-1:0] pipe_data_q [PIPELINE];
  logic [DATA_WIDTH-1:0] pipe_data_d [PIPELINE];
  logic [PIPELINE-1:0]   pipe_valid_q, pipe_valid_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  ptr_t                  fifo_wr_ptr_q, fifo_wr_ptr_d;
  ptr_t                  fifo_rd_ptr_q, fifo_rd_ptr_d;
  ptr_t                  occ_q, occ_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_done_q, wr_done_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic rd_accept_s, wr_accept_s, push_s, pop_s;

  // Handshake qualifiers, all taken from registered readies/valids.
  always_comb begin
    rd_accept_s = rd_valid && rd_ready_q;
    wr_accept_s = wr_valid && wr_ready_q;
    push_s      = pipe_valid_q[PIPELINE-1];
    pop_s       = resp_valid_q && resp_ready;
  end

  // Storage is not reset; nonblocking update makes a same-cycle read see the old word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_accept_s && wr_be[b]) begin
        ram[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline, FIFO and credit next-state.
  always_comb begin
    pipe_valid_d    = '0;
    pipe_data_d[0]  = rd_accept_s ? ram[rd_addr] : pipe_data_q[0];
    pipe_valid_d[0] = rd_accept_s;
    for (int i = 1; i < PIPELINE; i++) begin
      pipe_data_d[i]  = pipe_data_q[i-1];
      pipe_valid_d[i] = pipe_valid_q[i-1];
    end

    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_mem_d[i] = (push_s && (fifo_wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == FIFO_ADDR_WIDTH'(i)))
                      ? pipe_data_q[PIPELINE-1] : fifo_mem_q[i];
    end
    fifo_wr_ptr_d = fifo_wr_ptr_q + ptr_t'(push_s);
    fifo_rd_ptr_d = fifo_rd_ptr_q + ptr_t'(pop_s);

    // Credit covers both the pipeline and the FIFO, so a push can never find the FIFO full.
    occ_d        = occ_q + ptr_t'(rd_accept_s) - ptr_t'(pop_s);
    rd_ready_d   = (occ_d < CREDIT_LIMIT);
    wr_ready_d   = 1'b1;
    wr_done_d    = wr_accept_s;
    resp_valid_d = (fifo_wr_ptr_d != fifo_rd_ptr_d);
    resp_data_d  = fifo_mem_d[fifo_rd_ptr_d[FIFO_ADDR_WIDTH-1:0]];
  end

  // Control and datapath registers; reset drops every in-flight read and queued response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE; i++) pipe_data_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      pipe_valid_q  <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      occ_q         <= '0;
      rd_ready_q    <= 1'b0;
      wr_ready_q    <= 1'b0;
      wr_done_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      pipe_data_q   <= pipe_data_d;
      fifo_mem_q    <= fifo_mem_d;
      pipe_valid_q  <= pipe_valid_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      occ_q         <= occ_d;
      rd_ready_q    <= rd_ready_d;
      wr_ready_q    <= wr_ready_d;
      wr_done_q     <= wr_done_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

`ifdef DMA_SEG_RAM_RD_STAT_EN
  logic [STAT_WIDTH-1:0] stat_count_q, stat_count_d;

  // Completed responses, wrapping naturally at the counter width.
  always_comb begin
    stat_count_d = stat_count_q + STAT_WIDTH'(pop_s);
  end

  // Statistics register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count_q <= '0;
    end else begin
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`endif

  assign wr_ready   = wr_ready_q;
  assign wr_done    = wr_done_q;
  assign rd_ready   = rd_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: rtl/dma_seg_ram_rd.sv
// Segmented RAM read responder: SEG_COUNT independent dma_seg_ram_rd_seg lanes behind one bus.
// DMA_SEG_RAM_RD_STAT_EN adds rd_stat_count (per-segment completed responses).
module dma_seg_ram_rd
  import dma_seg_ram_pkg::*;
#(
  parameter int SEG_COUNT       = 2,
  parameter int SEG_DATA_WIDTH  = 64,
  parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH  = 8,
  parameter int RAM_SEL_WIDTH   = 2,
  parameter int PIPELINE        = 2,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  dma_seg_ram_rd_if.slave  bus
`ifdef DMA_SEG_RAM_RD_STAT_EN
  ,
  output logic [SEG_COUNT*STAT_WIDTH-1:0] rd_stat_count
`endif
);

  if (SEG_COUNT < 1) begin : g_bad_seg_count
    $fatal(1, "dma_seg_ram_rd: SEG_COUNT must be at least 1");
  end
  if ((SEG_DATA_WIDTH % 8) != 0 || SEG_BE_WIDTH != SEG_DATA_WIDTH / 8) begin : g_bad_width
    $fatal(1, "dma_seg_ram_rd: SEG_DATA_WIDTH must be a multiple of 8 with one enable per byte");
  end
  if (RAM_SEL_WIDTH < 0 || SEG_ADDR_WIDTH < 1) begin : g_bad_addr
    $fatal(1, "dma_seg_ram_rd: illegal RAM_SEL_WIDTH or SEG_ADDR_WIDTH");
  end
  if (PIPELINE < PIPELINE_MIN || PIPELINE > PIPELINE_MAX) begin : g_bad_pipeline
    $fatal(1, "dma_seg_ram_rd: PIPELINE out of range");
  end
  if (FIFO_ADDR_WIDTH < min_fifo_addr_width(PIPELINE)) begin : g_bad_fifo
    $fatal(1, "dma_seg_ram_rd: FIFO_ADDR_WIDTH too small for PIPELINE");
  end

  // The select field carries no meaning at the RAM end.
  logic sel_unused_s;
  assign sel_unused_s = ^bus.rd_cmd_sel;

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    dma_seg_ram_rd_seg #(
      .DATA_WIDTH      (SEG_DATA_WIDTH),
      .BE_WIDTH        (SEG_BE_WIDTH),
      .ADDR_WIDTH      (SEG_ADDR_WIDTH),
      .PIPELINE        (PIPELINE),
      .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_seg (
      .clk        (clk),
      .rst        (rst),
      .wr_be      (bus.wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
      .wr_addr    (bus.wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .wr_data    (bus.wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .wr_valid   (bus.wr_cmd_valid[n]),
      .wr_ready   (bus.wr_cmd_ready[n]),
      .wr_done    (bus.wr_done[n]),
      .rd_addr    (bus.rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .rd_valid   (bus.rd_cmd_valid[n]),
      .rd_ready   (bus.rd_cmd_ready[n]),
      .resp_data  (bus.rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .resp_valid (bus.rd_resp_valid[n]),
      .resp_ready (bus.rd_resp_ready[n])
`ifdef DMA_SEG_RAM_RD_STAT_EN
      ,
      .stat_count (rd_stat_count[n*STAT_WIDTH +: STAT_WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_dma_seg_ram_rd.sv
// Directed and scoreboarded checks for dma_seg_ram_rd (PIPELINE=2, 8-entry FIFO, two segments).
module tb_dma_seg_ram_rd;

  localparam int SC = 2;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int AW = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acc;
  int   guard;

  logic [63:0] mdl [SC][256];
  logic [63:0] exp_q [SC][$];
  int          hs_cnt [SC];

  dma_seg_ram_rd_if #(.SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_BE_WIDTH(BW),
                      .SEG_ADDR_WIDTH(AW), .RAM_SEL_WIDTH(SW)) bus ();

`ifdef DMA_SEG_RAM_RD_STAT_EN
  logic [SC*32-1:0] stat;
`endif

  dma_seg_ram_rd #(.SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_BE_WIDTH(BW), .SEG_ADDR_WIDTH(AW),
                   .RAM_SEL_WIDTH(SW), .PIPELINE(2), .FIFO_ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMA_SEG_RAM_RD_STAT_EN
    ,
    .rd_stat_count (stat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int n, input int a);
    if (a == 9) return 64'h0;
    return {8'hD0 + 8'(n), 24'h0, 24'h5A5A5A, 8'(a)};
  endfunction

  task automatic set_rd(input int n, input logic v, input logic [7:0] a);
    bus.rd_cmd_valid[n]      = v;
    bus.rd_cmd_addr[n*AW+:AW] = a;
    bus.rd_cmd_sel[n*SW+:SW]  = 2'(n);
  endtask

  task automatic set_wr(input int n, input logic v, input logic [7:0] a,
                        input logic [63:0] d, input logic [7:0] be);
    bus.wr_cmd_valid[n]       = v;
    bus.wr_cmd_addr[n*AW+:AW] = a;
    bus.wr_cmd_data[n*DW+:DW] = d;
    bus.wr_cmd_be[n*BW+:BW]   = be;
  endtask

  // One clock with scoreboard bookkeeping on every handshake seen at that edge.
  task automatic cycle_sb();
    logic [SC-1:0] wr_hs;
    logic [7:0]    a;
    logic [63:0]   d;
    for (int n = 0; n < SC; n++) begin
      wr_hs[n] = bus.wr_cmd_valid[n] && bus.wr_cmd_ready[n];
      if (bus.rd_resp_valid[n] && bus.rd_resp_ready[n]) begin
        check("resp_expected", 64'(exp_q[n].size() != 0), 64'd1);
        if (exp_q[n].size() != 0) check("resp_data", bus.rd_resp_data[n*DW+:DW], exp_q[n].pop_front());
        hs_cnt[n]++;
      end
      if (bus.rd_cmd_valid[n] && bus.rd_cmd_ready[n]) begin
        a = bus.rd_cmd_addr[n*AW+:AW];
        exp_q[n].push_back(mdl[n][a]);
      end
      if (wr_hs[n]) begin
        a = bus.wr_cmd_addr[n*AW+:AW];
        d = bus.wr_cmd_data[n*DW+:DW];
        for (int b = 0; b < BW; b++) begin
          if (bus.wr_cmd_be[n*BW+b]) mdl[n][a][8*b+:8] = d[8*b+:8];
        end
      end
    end
    step();
    check("wr_done", 64'(bus.wr_done), 64'(wr_hs));
  endtask

  // Single read into an empty FIFO with rd_resp_ready held high.
  task automatic read_one(input int n, input logic [7:0] a, input logic [63:0] exp, input string tag);
    set_rd(n, 1'b1, a);
    step();
    set_rd(n, 1'b0, a);
    step();
    check({tag, "_early"}, 64'(bus.rd_resp_valid[n]), 64'd0);
    step();
    check({tag, "_valid"}, 64'(bus.rd_resp_valid[n]), 64'd1);
    check({tag, "_data"}, bus.rd_resp_data[n*DW+:DW], exp);
    step();
    check({tag, "_single"}, 64'(bus.rd_resp_valid[n]), 64'd0);
  endtask

  initial begin
    bus.wr_cmd_be = '0;  bus.wr_cmd_addr = '0;  bus.wr_cmd_data = '0;  bus.wr_cmd_valid = '0;
    bus.rd_cmd_sel = '0; bus.rd_cmd_addr = '0;  bus.rd_cmd_valid = '0; bus.rd_resp_ready = '0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;

    // Reset state
    step();
    step();
    check("rst_rd_cmd_ready", 64'(bus.rd_cmd_ready), 64'd0);
    check("rst_wr_cmd_ready", 64'(bus.wr_cmd_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.rd_resp_valid), 64'd0);
    check("rst_wr_done", 64'(bus.wr_done), 64'd0);
    check("rst_resp_data0", bus.rd_resp_data[63:0], 64'd0);
    check("rst_resp_data1", bus.rd_resp_data[127:64], 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_rd_ready", 64'(bus.rd_cmd_ready), 64'd3);
    check("post_rst_wr_ready", 64'(bus.wr_cmd_ready), 64'd3);

    // Fill addresses 0..15 of both segments
    for (int a = 0; a < 16; a++) begin
      for (int n = 0; n < SC; n++) set_wr(n, 1'b1, 8'(a), pat(n, a), 8'hFF);
      cycle_sb();
    end
    for (int n = 0; n < SC; n++) set_wr(n, 1'b0, 8'd0, 64'd0, 8'h00);
    cycle_sb();

    // Full write then single-byte rewrite
    set_wr(0, 1'b1, 8'd5, 64'h1122334455667788, 8'hFF);
    cycle_sb();
    set_wr(0, 1'b1, 8'd5, 64'h00000000000000AA, 8'h01);
    cycle_sb();
    set_wr(0, 1'b0, 8'd0, 64'd0, 8'h00);
    cycle_sb();
    bus.rd_resp_ready = 2'b11;
    read_one(0, 8'd5, 64'h11223344556677AA, "partial_be");

    // Back-to-back reads 0..15 on both segments
    for (int k = 0; k < 18; k++) begin
      for (int n = 0; n < SC; n++) set_rd(n, k < 16, 8'(k));
      step();
      if (k < 16) check("b2b_ready", 64'(bus.rd_cmd_ready), 64'd3);
      if (k >= 2) begin
        for (int n = 0; n < SC; n++) begin
          check("b2b_valid", 64'(bus.rd_resp_valid[n]), 64'd1);
          check("b2b_data", bus.rd_resp_data[n*DW+:DW], mdl[n][k-2]);
        end
      end
    end
    for (int n = 0; n < SC; n++) set_rd(n, 1'b0, 8'd0);

    // Same-cycle write and read at address 9
    set_wr(0, 1'b1, 8'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    set_rd(0, 1'b1, 8'd9);
    step();
    set_wr(0, 1'b0, 8'd0, 64'd0, 8'h00);
    set_rd(0, 1'b0, 8'd0);
    mdl[0][9] = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("coll_early", 64'(bus.rd_resp_valid[0]), 64'd0);
    step();
    check("coll_valid", 64'(bus.rd_resp_valid[0]), 64'd1);
    check("coll_old_data", bus.rd_resp_data[63:0], 64'd0);
    read_one(0, 8'd9, 64'hFFFF_FFFF_FFFF_FFFF, "coll_after");

    // Credit limit with the response channel stalled
    bus.rd_resp_ready[0] = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      set_rd(0, 1'b1, 8'(acc % 16));
      if (bus.rd_cmd_ready[0]) acc++;
      cycle_sb();
    end
    check("bp_accepted", 64'(acc), 64'd8);
    check("bp_ready_low", 64'(bus.rd_cmd_ready[0]), 64'd0);
    check("bp_resp_pending", 64'(bus.rd_resp_valid[0]), 64'd1);
    bus.rd_resp_ready[0] = 1'b1;
    set_rd(0, 1'b1, 8'(acc % 16));
    if (bus.rd_cmd_ready[0]) acc++;
    cycle_sb();
    check("bp_ready_after_pop", 64'(bus.rd_cmd_ready[0]), 64'd1);
    guard = 0;
    while ((acc < 20 || exp_q[0].size() != 0) && guard < 200) begin
      set_rd(0, acc < 20, 8'(acc % 16));
      if (bus.rd_cmd_valid[0] && bus.rd_cmd_ready[0]) acc++;
      cycle_sb();
      guard++;
    end
    set_rd(0, 1'b0, 8'd0);
    check("bp_total_accepted", 64'(acc), 64'd20);
    check("bp_drained", 64'(exp_q[0].size()), 64'd0);

    // Reset with reads in flight and queued
    bus.rd_resp_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_rd(0, 1'b1, 8'(i + 1));
      cycle_sb();
    end
    set_rd(0, 1'b0, 8'd0);
    check("mid_pending", 64'(bus.rd_resp_valid[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rd_ready", 64'(bus.rd_cmd_ready), 64'd0);
    check("mid_rst_wr_ready", 64'(bus.wr_cmd_ready), 64'd0);
    check("mid_rst_resp_valid", 64'(bus.rd_resp_valid), 64'd0);
    check("mid_rst_wr_done", 64'(bus.wr_done), 64'd0);
    check("mid_rst_resp_data0", bus.rd_resp_data[63:0], 64'd0);
    check("mid_rst_resp_data1", bus.rd_resp_data[127:64], 64'd0);
    for (int n = 0; n < SC; n++) begin
      exp_q[n].delete();
      hs_cnt[n] = 0;
    end
    step();
    step();
    rst = 1'b0;
    bus.rd_resp_ready = 2'b11;
    for (int i = 0; i < 10; i++) begin
      check("no_stale_resp", 64'(bus.rd_resp_valid), 64'd0);
      cycle_sb();
    end
    bus.rd_resp_ready[0] = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      set_rd(0, 1'b1, 8'(acc % 16));
      if (bus.rd_cmd_ready[0]) acc++;
      cycle_sb();
    end
    check("post_rst_credit", 64'(acc), 64'd8);
    set_rd(0, 1'b0, 8'd0);
    bus.rd_resp_ready[0] = 1'b1;
    guard = 0;
    while (exp_q[0].size() != 0 && guard < 50) begin
      cycle_sb();
      guard++;
    end
    check("post_rst_drained", 64'(exp_q[0].size()), 64'd0);

    // Random independent traffic
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < SC; n++) begin
        set_rd(n, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)));
        set_wr(n, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)),
               {$urandom, $urandom}, 8'($urandom));
        bus.rd_resp_ready[n] = 1'($urandom_range(0, 1));
      end
      cycle_sb();
    end
    for (int n = 0; n < SC; n++) begin
      set_rd(n, 1'b0, 8'd0);
      set_wr(n, 1'b0, 8'd0, 64'd0, 8'h00);
    end
    bus.rd_resp_ready = 2'b11;
    guard = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 50) begin
      cycle_sb();
      guard++;
    end
    check("rand_drained0", 64'(exp_q[0].size()), 64'd0);
    check("rand_drained1", 64'(exp_q[1].size()), 64'd0);
`ifdef DMA_SEG_RAM_RD_STAT_EN
    check("stat_count0", 64'(stat[31:0]), 64'(hs_cnt[0]));
    check("stat_count1", 64'(stat[63:32]), 64'(hs_cnt[1]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
